// File: rtl/sobel_window_feeder.sv
// Streams the WIN x WIN neighbourhood around a requested centre pixel from a
// synchronous-read frame memory, one pixel per valid/ready handshake, replicating edge pixels.
module sobel_window_feeder #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int ADDR_W = 12,
   parameter int WIN    = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [7:0]        req_x,
   input  logic [7:0]        req_y,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [7:0]        pix_data,
   output logic [5:0]        pix_index,
   output logic              pix_last,
   output logic              busy,
   output logic              done
);

   localparam logic        [5:0] LAST_IDX = 6'(WIN*WIN-1);
   localparam logic        [2:0] COL_LAST = 3'(WIN-1);
   localparam logic        [7:0] X_LIM    = 8'(IMG_W-1);
   localparam logic        [7:0] Y_LIM    = 8'(IMG_H-1);
   localparam logic signed [9:0] X_MAX    = 10'(IMG_W-1);
   localparam logic signed [9:0] Y_MAX    = 10'(IMG_H-1);
   localparam logic signed [9:0] HALF_S   = 10'(WIN/2);

   typedef enum logic [2:0] {IDLE, READ, CAPT, SEND, DONE} state_t;

   state_t            state_q, state_d;
   logic [7:0]        centerX_q, centerY_q;
   logic [5:0]        idx_q;
   logic [2:0]        col_q, row_q;
   logic [ADDR_W-1:0] memAddr_q;
   logic [7:0]        pixData_q;
   logic [5:0]        pixIndex_q;
   logic              pixLast_q;

   logic signed [9:0] sx, sy;
   logic [7:0]        xc, yc;
   logic [ADDR_W-1:0] addrCalc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = READ;
         READ:    state_d = CAPT;
         CAPT:    state_d = SEND;
         SEND:    if (pix_ready) state_d = pixLast_q ? DONE : READ;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Offsets are applied in signed arithmetic so negative coordinates clamp to the edge.
   always_comb begin
      sx = $signed({2'b00, centerX_q}) + $signed({7'b0, col_q}) - HALF_S;
      sy = $signed({2'b00, centerY_q}) + $signed({7'b0, row_q}) - HALF_S;
      if (sx[9])           xc = 8'd0;
      else if (sx > X_MAX) xc = X_LIM;
      else                 xc = sx[7:0];
      if (sy[9])           yc = 8'd0;
      else if (sy > Y_MAX) yc = Y_LIM;
      else                 yc = sy[7:0];
      addrCalc = ADDR_W'(({24'b0, yc} * 32'(IMG_W)) + {24'b0, xc});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         centerX_q  <= '0;
         centerY_q  <= '0;
         idx_q      <= '0;
         col_q      <= '0;
         row_q      <= '0;
         memAddr_q  <= '0;
         pixData_q  <= '0;
         pixIndex_q <= '0;
         pixLast_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (req_valid) begin
               centerX_q <= (req_x > X_LIM) ? X_LIM : req_x;
               centerY_q <= (req_y > Y_LIM) ? Y_LIM : req_y;
               idx_q     <= '0;
               col_q     <= '0;
               row_q     <= '0;
            end
            READ: memAddr_q <= addrCalc;
            CAPT: begin
               pixData_q  <= mem_rdata;
               pixIndex_q <= idx_q;
               pixLast_q  <= (idx_q == LAST_IDX);
            end
            SEND: if (pix_ready && !pixLast_q) begin
               idx_q <= idx_q + 6'd1;
               if (col_q == COL_LAST) begin
                  col_q <= '0;
                  row_q <= row_q + 3'd1;
               end else begin
                  col_q <= col_q + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // The address register keeps the last issued address visible between reads.
   assign mem_rd_en = (state_q == READ);
   assign mem_addr  = (state_q == READ) ? addrCalc : memAddr_q;
   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q == READ) || (state_q == CAPT) || (state_q == SEND);
   assign done      = (state_q == DONE);
   assign pix_valid = (state_q == SEND);
   assign pix_data  = pixData_q;
   assign pix_index = pixIndex_q;
   assign pix_last  = pixLast_q;

endmodule

// File: tb/tb_sobel_window_feeder.sv
// Self-checking bench for sobel_window_feeder: directed table, backpressure,
// abort and ignored-request sequences, plus randomized windows against a clamp model.
module tb_sobel_window_feeder;

   localparam int IMG_W  = 64;
   localparam int IMG_H  = 64;
   localparam int ADDR_W = 12;
   localparam int WIN    = 5;
   localparam int NPIX   = WIN*WIN;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid, req_ready;
   logic [7:0]        req_x, req_y;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata = 8'd0;
   logic              pix_valid, pix_ready;
   logic [7:0]        pix_data;
   logic [5:0]        pix_index;
   logic              pix_last, busy, done;

   logic [7:0] mem [0:(1<<ADDR_W)-1];

   int checks = 0;
   int failures = 0;

   int capAddr[$];
   int capData[$];
   int capIdx[$];
   int capLast[$];
   int doneCycle, firstValid, stableErr, rdWhileValid, reqReadyBad;
   int postReqReady, postBusy;

   typedef struct {
      int rx;
      int ry;
      int idx;
      int addr;
   } vec_t;
   vec_t vecs[10];

   sobel_window_feeder #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .WIN(WIN)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .pix_index(pix_index), .pix_last(pix_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Frame memory with one cycle of read latency.
   always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

   function automatic void expectEq(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   function automatic int clampInt(int v, int lo, int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   // Reference: clamp the centre, offset by the window position, clamp again.
   function automatic int modelAddr(int rx, int ry, int idx);
      int cx, cy, x, y;
      cx = clampInt(rx, 0, IMG_W-1);
      cy = clampInt(ry, 0, IMG_H-1);
      x  = clampInt(cx + (idx % WIN) - WIN/2, 0, IMG_W-1);
      y  = clampInt(cy + (idx / WIN) - WIN/2, 0, IMG_H-1);
      return y*IMG_W + x;
   endfunction

   // Issues one request and records reads and handshaken pixels until done.
   task automatic applyStimulus(input int rx, input int ry, input int stallAt, input int stallLen,
                                input int pulseAt, input bit randReady);
      int w, stallCnt;
      bit prevStalled, pulsed;
      int prevData, prevIdx, prevLast;
      capAddr.delete(); capData.delete(); capIdx.delete(); capLast.delete();
      doneCycle = -1; firstValid = -1; stableErr = 0; rdWhileValid = 0; reqReadyBad = 0;
      stallCnt = 0; prevStalled = 0; pulsed = 0;
      prevData = 0; prevIdx = 0; prevLast = 0;
      @(negedge clk);
      w = 0;
      while (!req_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      req_x = 8'(rx); req_y = 8'(ry); req_valid = 1'b1; pix_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (mem_rd_en) begin
            capAddr.push_back(int'(mem_addr));
            if (pix_valid) rdWhileValid++;
         end
         if (done) begin
            doneCycle = k;
            break;
         end
         if (pix_valid) begin
            if (firstValid < 0) firstValid = k;
            if (prevStalled && (int'(pix_data) != prevData || int'(pix_index) != prevIdx ||
                                int'(pix_last) != prevLast)) stableErr++;
            if (int'(pix_index) == stallAt && stallCnt < stallLen) begin
               pix_ready = 1'b0;
               stallCnt++;
            end else if (randReady) pix_ready = ($urandom_range(0, 2) != 0);
            else pix_ready = 1'b1;
            prevStalled = !pix_ready;
            prevData = int'(pix_data); prevIdx = int'(pix_index); prevLast = int'(pix_last);
            if (pix_ready) begin
               capData.push_back(int'(pix_data));
               capIdx.push_back(int'(pix_index));
               capLast.push_back(int'(pix_last));
            end
            if (int'(pix_index) == pulseAt && !pulsed) begin
               pulsed = 1'b1;
               req_valid = 1'b1; req_x = 8'd0; req_y = 8'd0;
               if (req_ready) reqReadyBad++;
            end
         end else begin
            if (prevStalled) stableErr++;
            prevStalled = 1'b0;
            pix_ready = randReady ? ($urandom_range(0, 1) != 0) : 1'b1;
         end
         @(negedge clk);
         req_valid = 1'b0;
      end
      pix_ready = 1'b1;
      @(negedge clk);
      postReqReady = int'(req_ready);
      postBusy = int'(busy);
   endtask

   // Compares the recorded window with the reference model.
   task automatic checkOutput(input int rx, input int ry, input int expDone);
      expectEq("read_count", capAddr.size(), NPIX);
      expectEq("pixel_count", capData.size(), NPIX);
      for (int i = 0; i < NPIX; i++) begin
         if (i < capAddr.size()) expectEq($sformatf("addr[%0d]", i), capAddr[i], modelAddr(rx, ry, i));
         if (i < capData.size()) begin
            expectEq($sformatf("data[%0d]", i), capData[i], int'(mem[modelAddr(rx, ry, i)]));
            expectEq($sformatf("index[%0d]", i), capIdx[i], i);
            expectEq($sformatf("last[%0d]", i), capLast[i], (i == NPIX-1) ? 1 : 0);
         end
      end
      expectEq("stable_under_stall", stableErr, 0);
      expectEq("read_while_valid", rdWhileValid, 0);
      if (expDone >= 0) expectEq("done_cycle", doneCycle, expDone);
      else expectEq("done_seen", (doneCycle >= 0) ? 1 : 0, 1);
      expectEq("post_req_ready", postReqReady, 1);
      expectEq("post_busy", postBusy, 0);
   endtask

   initial begin
      int w;
      vecs[0] = '{10, 10, 0, 520};
      vecs[1] = '{10, 10, 24, 780};
      vecs[2] = '{0, 0, 0, 0};
      vecs[3] = '{0, 0, 1, 0};
      vecs[4] = '{0, 0, 2, 0};
      vecs[5] = '{0, 0, 12, 0};
      vecs[6] = '{0, 0, 24, 130};
      vecs[7] = '{63, 63, 24, 4095};
      vecs[8] = '{63, 63, 0, 3965};
      vecs[9] = '{200, 5, 12, 383};
      for (int a = 0; a < (1<<ADDR_W); a++) mem[a] = 8'(a);

      rst_n = 1'b0; req_valid = 1'b0; req_x = 8'd0; req_y = 8'd0; pix_ready = 1'b1;
      #12;
      expectEq("rst_req_ready", int'(req_ready), 1);
      expectEq("rst_busy", int'(busy), 0);
      expectEq("rst_pix_valid", int'(pix_valid), 0);
      expectEq("rst_mem_rd_en", int'(mem_rd_en), 0);
      expectEq("rst_done", int'(done), 0);
      expectEq("rst_mem_addr", int'(mem_addr), 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] directed table");
      for (int v = 0; v < 10; v++) begin
         applyStimulus(vecs[v].rx, vecs[v].ry, -1, 0, -1, 1'b0);
         if (vecs[v].idx < capAddr.size())
            expectEq($sformatf("tbl%0d_addr", v), capAddr[vecs[v].idx], vecs[v].addr);
         else expectEq($sformatf("tbl%0d_addr_present", v), 0, 1);
         if (vecs[v].idx < capData.size())
            expectEq($sformatf("tbl%0d_data", v), capData[vecs[v].idx], vecs[v].addr % 256);
         else expectEq($sformatf("tbl%0d_data_present", v), 0, 1);
         expectEq($sformatf("tbl%0d_first_valid", v), firstValid, 2);
         checkOutput(vecs[v].rx, vecs[v].ry, 75);
      end

      $display("[TB] backpressure at idx3");
      applyStimulus(10, 10, 3, 5, -1, 1'b0);
      checkOutput(10, 10, 80);

      $display("[TB] request while busy");
      applyStimulus(10, 10, -1, 0, 5, 1'b0);
      expectEq("busy_req_ready", reqReadyBad, 0);
      checkOutput(10, 10, 75);

      $display("[TB] reset mid-window");
      @(negedge clk);
      req_x = 8'd10; req_y = 8'd10; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      w = 0;
      while (!(pix_valid && pix_index == 6'd12) && w < 200) begin
         @(negedge clk);
         w++;
      end
      expectEq("abort_reach_idx12", (w < 200) ? 1 : 0, 1);
      #2 rst_n = 1'b0;
      #1;
      expectEq("abort_pix_valid", int'(pix_valid), 0);
      expectEq("abort_busy", int'(busy), 0);
      expectEq("abort_mem_rd_en", int'(mem_rd_en), 0);
      expectEq("abort_pix_index", int'(pix_index), 0);
      expectEq("abort_req_ready", int'(req_ready), 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      w = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (done) w++;
      end
      expectEq("abort_no_done", w, 0);
      applyStimulus(10, 10, -1, 0, -1, 1'b0);
      if (capAddr.size() > 0) expectEq("restart_addr0", capAddr[0], 520);
      else expectEq("restart_addr_present", 0, 1);
      if (capIdx.size() > 0) expectEq("restart_idx0", capIdx[0], 0);
      else expectEq("restart_idx_present", 0, 1);
      checkOutput(10, 10, 75);

      $display("[TB] randomized windows");
      for (int a = 0; a < (1<<ADDR_W); a++) mem[a] = 8'($urandom);
      for (int r = 0; r < 20; r++) begin
         int rx, ry;
         rx = $urandom_range(0, 255);
         ry = (r % 4 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
         applyStimulus(rx, ry, -1, 0, -1, 1'b1);
         checkOutput(rx, ry, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sobel_window_feeder.md
Name: sobel_window_feeder

Overview:
Transmit side of the serial pixel-window interface used by the Sobel gradient stage. For each requested center coordinate, the block reads the 5x5 neighbourhood from a frame memory with 1-cycle synchronous read latency. It streams the 25 pixels in row-major order, one per valid/ready handshake, and clamps coordinates at image borders. It sits between the frame buffer and the gradient/Harris pipeline.

Parameters:
IMG_W, 64, image width in pixels (2..256)
IMG_H, 64, image height in pixels (2..256)
ADDR_W, 12, frame memory address width; must satisfy IMG_W*IMG_H <= 2^ADDR_W
WIN, 5, window side length; odd, 3..7; pixels per window = WIN*WIN

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  window request strobe
req_ready  out  1  high when a request can be accepted
req_x  in  8  center column
req_y  in  8  center row
mem_rd_en  out  1  frame memory read enable
mem_addr  out  ADDR_W  frame memory read address
mem_rdata  in  8  read data, valid the cycle after mem_rd_en
pix_valid  out  1  pix_data is valid
pix_ready  in  1  downstream accepts pixel
pix_data  out  8  window pixel
pix_index  out  6  index of current pixel, 0..WIN*WIN-1
pix_last  out  1  high with the final pixel of a window
busy  out  1  high from request accept until done
done  out  1  one-cycle pulse after the final pixel handshake

Behaviour:
- Reset (async, rst_n low): state=IDLE. req_ready=1, all other outputs 0, counters 0. Release takes effect on the next clk edge.
- FSM states and transitions:
  - IDLE: req_ready=1. If req_valid, latch req_x/req_y, clamping each to IMG_W-1 / IMG_H-1. Set idx=0, busy=1, go to READ.
  - READ: for window offset (dx,dy) = (idx mod WIN - WIN/2, idx div WIN - WIN/2):
    - Compute x = clamp(cx+dx, 0, IMG_W-1) and y = clamp(cy+dy, 0, IMG_H-1).
    - Compute in signed 10-bit arithmetic before clamping.
    - Drive mem_addr = y*IMG_W + x and mem_rd_en=1 for exactly one cycle. Go to CAPT.
  - CAPT: register mem_rdata into pix_data. Set pix_valid=1, pix_index=idx, pix_last=(idx==WIN*WIN-1). Go to SEND.
  - SEND: hold pix_data/pix_index/pix_last stable while pix_ready=0. On pix_valid&&pix_ready, drop pix_valid next cycle.
    - If pix_last: go to DONE.
    - Else: idx+1, go to READ.
  - DONE: done=1 for one cycle, busy=0, go to IDLE (req_ready=1 from next cycle).
- Latency: first pix_valid 3 cycles after the request-accept edge. Peak rate is 1 pixel per 3 cycles with pix_ready tied high. One window takes 3*WIN*WIN+2 cycles (77 for WIN=5).
- req_ready=0 outside IDLE. req_valid asserted while busy is ignored and not queued.
- mem_rd_en is never asserted while pix_valid=1. Backpressure produces no extra reads.
- mem_addr holds its last value when mem_rd_en=0.
- Border clamping replicates edge pixels; no zero padding.
- Reset mid-window: the stream aborts immediately and no done pulse is produced. The next request restarts at idx 0.
- pix_valid, once asserted, never deasserts before the handshake.

Test Plan:
- mem[a]=a[7:0], IMG_W=64, request (10,10), pix_ready=1 -> 25 pixels. idx0 mem_addr=520, pix_data=8. idx24 mem_addr=780, pix_data=12, pix_last=1. done pulse follows, 77 cycles total.
- Corner request (0,0) -> idx0..2 addr 0,0,0. idx12 addr 0. idx24 addr 130. No addr outside 0..4095.
- Request (63,63) on 64x64 -> idx24 addr 4095, idx0 addr 61*64+61=3965.
- Request (200,5) with IMG_W=64 -> treated as (63,5); idx12 addr 383.
- pix_ready held low 5 cycles at idx3 -> pix_data/pix_index stable, mem_rd_en stays 0, stream resumes at idx4.
- rst_n low during idx12 -> outputs 0 asynchronously, req_ready=1 after release. Next request (10,10) restarts at idx0, addr 520.
- req_valid pulsed at idx5 -> ignored, req_ready=0, window unaffected.
